// File: rtl/q_update_ctrl.sv
// q_update_ctrl: sequences one tabular Q-learning update over a 16x16 Q table
// that is stored as 16 per-action RAMs (one row per state) behind a 16:1 read mux.
//   Q(s,a) <= Q(s,a) + alpha * (reward + gamma * max_k Q(s',k) - Q(s,a))
// All values are signed Q8.8. One update occupies 20 busy cycles:
// RDQ(1) + SCAN(16) + DRAIN(1) + CALC(1) + WRITE(1).
// Every output port is driven straight from a flop; the flops are loaded from
// the next-state decode so that each output is valid in the same cycle as the
// state it belongs to.
module q_update_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  state,
    input  logic [3:0]  next_state,
    input  logic [3:0]  action,
    input  logic [15:0] reward,
    input  logic [15:0] alpha,
    input  logic [15:0] gamma,
    output logic [3:0]  ram_rd_addr,
    output logic [3:0]  ram_rd_sel,
    input  logic [15:0] ram_rd_data,
    output logic [3:0]  ram_wr_addr,
    output logic [15:0] ram_wr_en,
    output logic [15:0] ram_wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RDQ   = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CALC  = 3'd4,
        ST_WRITE = 3'd5
    } fsm_t;

    // Sign-extend a Q8.8 value into the wide arithmetic domain.
    function automatic logic signed [47:0] sext16(input logic [15:0] v);
        sext16 = $signed({{32{v[15]}}, v});
    endfunction

    // Clamp a wide signed result to the Q8.8 range.
    function automatic logic [15:0] sat16(input logic signed [47:0] v);
        if (v > 48'sd32767) begin
            sat16 = 16'h7FFF;
        end else if (v < -48'sd32768) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    fsm_t        fsm_r;
    fsm_t        fsm_nxt_s;
    logic [3:0]  scan_k_r;
    logic [3:0]  scan_k_nxt_s;

    // Operands latched at start so later input changes cannot disturb the update.
    logic [3:0]  s_r;
    logic [3:0]  sp_r;
    logic [3:0]  a_r;
    logic [15:0] reward_r;
    logic [15:0] alpha_r;
    logic [15:0] gamma_r;

    logic [15:0] q_sa_r;
    logic [15:0] maxq_r;

    // Output flops.
    logic [3:0]  rd_addr_r;
    logic [3:0]  rd_sel_r;
    logic [3:0]  wr_addr_r;
    logic [15:0] wr_en_r;
    logic [15:0] wr_data_r;
    logic        busy_r;
    logic        done_r;

    // Next-cycle values for the output flops.
    logic [3:0]  rd_addr_nxt_s;
    logic [3:0]  rd_sel_nxt_s;
    logic [3:0]  wr_addr_nxt_s;
    logic [15:0] wr_en_nxt_s;
    logic [15:0] wr_data_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    // Datapath intermediates.
    logic signed [47:0] prod_g_s;
    logic signed [47:0] t_s;
    logic signed [47:0] prod_a_s;
    logic signed [47:0] d_s;
    logic signed [47:0] qn_s;
    logic [15:0]        qn_sat_s;

    assign ram_rd_addr = rd_addr_r;
    assign ram_rd_sel  = rd_sel_r;
    assign ram_wr_addr = wr_addr_r;
    assign ram_wr_en   = wr_en_r;
    assign ram_wr_data = wr_data_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Next-state logic and scan counter sequencing.
    always_comb begin
        fsm_nxt_s    = fsm_r;
        scan_k_nxt_s = 4'd0;
        case (fsm_r)
            ST_IDLE: begin
                if (start) begin
                    fsm_nxt_s = ST_RDQ;
                end else begin
                    fsm_nxt_s = ST_IDLE;
                end
            end
            ST_RDQ: begin
                fsm_nxt_s = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_k_r == 4'd15) begin
                    fsm_nxt_s = ST_DRAIN;
                end else begin
                    fsm_nxt_s    = ST_SCAN;
                    scan_k_nxt_s = scan_k_r + 4'd1;
                end
            end
            ST_DRAIN: begin
                fsm_nxt_s = ST_CALC;
            end
            ST_CALC: begin
                fsm_nxt_s = ST_WRITE;
            end
            ST_WRITE: begin
                fsm_nxt_s = ST_IDLE;
            end
            default: begin
                fsm_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Q update arithmetic; all operands are registers that are stable during CALC.
    always_comb begin
        prod_g_s = sext16(gamma_r) * sext16(maxq_r);
        t_s      = sext16(reward_r) + (prod_g_s >>> 8) - sext16(q_sa_r);
        prod_a_s = sext16(alpha_r) * t_s;
        d_s      = prod_a_s >>> 8;
        qn_s     = sext16(q_sa_r) + d_s;
        qn_sat_s = sat16(qn_s);
    end

    // Output decode from the state being entered. RDQ is only reachable from
    // IDLE, so its read address comes straight from the live inputs that are
    // being latched on the same edge.
    always_comb begin
        rd_addr_nxt_s = 4'd0;
        rd_sel_nxt_s  = 4'd0;
        wr_addr_nxt_s = 4'd0;
        wr_en_nxt_s   = 16'h0000;
        wr_data_nxt_s = 16'h0000;
        busy_nxt_s    = (fsm_nxt_s != ST_IDLE);
        done_nxt_s    = 1'b0;
        case (fsm_nxt_s)
            ST_RDQ: begin
                rd_addr_nxt_s = state;
                rd_sel_nxt_s  = action;
            end
            ST_SCAN: begin
                rd_addr_nxt_s = sp_r;
                rd_sel_nxt_s  = scan_k_nxt_s;
            end
            ST_WRITE: begin
                wr_addr_nxt_s = s_r;
                wr_en_nxt_s   = 16'h0001 << a_r;
                wr_data_nxt_s = qn_sat_s;
                done_nxt_s    = 1'b1;
            end
            default: begin
                rd_addr_nxt_s = 4'd0;
                rd_sel_nxt_s  = 4'd0;
            end
        endcase
    end

    // State register, scan counter and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r     <= ST_IDLE;
            scan_k_r  <= 4'd0;
            rd_addr_r <= 4'd0;
            rd_sel_r  <= 4'd0;
            wr_addr_r <= 4'd0;
            wr_en_r   <= 16'h0000;
            wr_data_r <= 16'h0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            fsm_r     <= fsm_nxt_s;
            scan_k_r  <= scan_k_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            rd_sel_r  <= rd_sel_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    // Operand latch on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r      <= 4'd0;
            sp_r     <= 4'd0;
            a_r      <= 4'd0;
            reward_r <= 16'h0000;
            alpha_r  <= 16'h0000;
            gamma_r  <= 16'h0000;
        end else if ((fsm_r == ST_IDLE) && start) begin
            s_r      <= state;
            sp_r     <= next_state;
            a_r      <= action;
            reward_r <= reward;
            alpha_r  <= alpha;
            gamma_r  <= gamma;
        end
    end

    // Read-data capture: RAM data lags the address by one cycle, so SCAN k=0
    // sees Q(s,a), SCAN k=1 sees the first row entry and DRAIN sees the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sa_r <= 16'h0000;
            maxq_r <= 16'h0000;
        end else begin
            case (fsm_r)
                ST_SCAN: begin
                    if (scan_k_r == 4'd0) begin
                        q_sa_r <= ram_rd_data;
                    end else if (scan_k_r == 4'd1) begin
                        maxq_r <= ram_rd_data;
                    end else if ($signed(ram_rd_data) > $signed(maxq_r)) begin
                        maxq_r <= ram_rd_data;
                    end
                end
                ST_DRAIN: begin
                    if ($signed(ram_rd_data) > $signed(maxq_r)) begin
                        maxq_r <= ram_rd_data;
                    end
                end
                default: begin
                    maxq_r <= maxq_r;
                end
            endcase
        end
    end

endmodule

// File: doc/q_update_ctrl.md
Q_UPDATE_CTRL -- requirements
Module: q_update_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request one Q-update; sampled only in IDLE.
REQ-004 SHALL have ports state, next_state, action, input, 4 bits each: s, s', a.
REQ-005 SHALL have ports reward, alpha, gamma, input, 16 bits each: signed Q8.8.
REQ-006 SHALL have port ram_rd_addr, output, 4 bits: state-row read address, shared by all 16 action RAMs.
REQ-007 SHALL have port ram_rd_sel, output, 4 bits: action select to the 16:1 output mux.
REQ-008 SHALL have port ram_rd_data, input, 16 bits: muxed RAM data, valid exactly 1 cycle after addr/sel.
REQ-009 SHALL have port ram_wr_addr, output, 4 bits: write row.
REQ-010 SHALL have port ram_wr_en, output, 16 bits: one-hot per-action-RAM write enable.
REQ-011 SHALL have port ram_wr_data, output, 16 bits: new Q value.
REQ-012 SHALL have port busy, output, 1 bit: high in every non-IDLE cycle.
REQ-013 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-014 SHALL latch state, next_state, action, reward, alpha and gamma on the edge where start=1 in IDLE, then enter RDQ; inputs changing afterwards SHALL NOT affect the update in progress.
REQ-015 SHALL implement the FSM IDLE -> RDQ (1 cycle) -> SCAN (16 cycles) -> DRAIN (1) -> CALC (1) -> WRITE (1) -> IDLE, making busy exactly 20 cycles per update.
REQ-016 RDQ SHALL drive ram_rd_addr=s and ram_rd_sel=a; the data returned in the next cycle SHALL be captured as q_sa.
REQ-017 SCAN cycle k (k=0..15) SHALL drive ram_rd_addr=s' and ram_rd_sel=k; the data returned in the next cycle SHALL update the running signed maximum maxq.
REQ-018 maxq SHALL be initialised from the k=0 data; DRAIN SHALL capture the k=15 data.
REQ-019 CALC SHALL compute the following in at least 34-bit signed arithmetic:
- t = reward + ((gamma*maxq) >>> 8) - q_sa
- d = (alpha*t) >>> 8
- qn = q_sa + d
Here >>> is an arithmetic (floor) shift.
REQ-020 qn SHALL be saturated to [0x8000, 0x7FFF] only at the final step, then registered.
REQ-021 WRITE SHALL drive ram_wr_addr=s, ram_wr_en=(1<<a), ram_wr_data=qn and done=1 for exactly one cycle.
REQ-022 Outside WRITE, ram_wr_en SHALL be 0 and done SHALL be 0.
REQ-023 start SHALL be ignored while busy=1, including during the WRITE cycle; a start in the first IDLE cycle after WRITE SHALL be accepted, allowing back-to-back updates every 21 cycles.
REQ-024 When s'==s, SCAN SHALL use pre-update values, since the write occurs only after SCAN.
REQ-025 ram_rd_addr and ram_rd_sel SHALL be 0 in IDLE, CALC, DRAIN and WRITE.

Reset
REQ-026 While rst=1, the controller SHALL force the FSM to IDLE and set busy, done, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_sel and all internal registers to 0.
REQ-027 Reset asserted mid-operation, including during WRITE, SHALL abort the update with no further RAM write; the first start after reset deassertion SHALL be serviced normally.

Verification
REQ-028 Nominal update:
- Stimulus: Q(3,5)=0x0100, row 7 max=0x0400 at action 9, reward=0x0200, alpha=0x0080, gamma=0x00E6, s=3, s'=7, a=5.
- Response: in WRITE, ram_wr_en=0x0020, ram_wr_addr=3, ram_wr_data=0x034C; done is high 20 cycles after the start edge.
REQ-029 Saturation:
- Stimulus: q_sa=0x7F00, maxq=0x7FFF, reward=0x7FFF, alpha=0x0100, gamma=0x0100.
- Response: ram_wr_data=0x7FFF.
REQ-030 Negative reward:
- Stimulus: all RAMs 0, reward=0xFF00, alpha=0x0100, gamma=0.
- Response: ram_wr_data=0xFF00.
REQ-031 Negative maximum:
- Stimulus: all 16 entries of row s' negative, with the largest 0xFFF0 at action 15.
- Response: maxq=0xFFF0.
- Check: the DRAIN capture is used, not the initial value.
REQ-032 Protocol and reset:
- Stimulus: start held high continuously.
- Response: exactly one done per 21 cycles.
- Stimulus: rst pulsed at SCAN k=8.
- Response: no ram_wr_en pulse; busy=0 immediately; a following start completes correctly.
